// File: rtl/ws2811_strip_controller_if.sv
// Frame-request, pixel-RAM and transmitter handshake bundle for the WS2811 strip controller.
`timescale 1ns/1ps
interface ws2811_strip_controller_if #(
  parameter int unsigned ADDR_WIDTH = 8
);
  logic                  frameStartIN;
  logic [7:0]            brightnessIN;
  logic                  frameBusyOUT;
  logic                  frameDoneOUT;
  logic [ADDR_WIDTH-1:0] pixAddrOUT;
  logic [23:0]           pixDataIN;
  logic                  txStartOUT;
  logic [23:0]           txDataOUT;
  logic                  txBusyIN;

  modport master (
    input  frameStartIN, brightnessIN, pixDataIN, txBusyIN,
    output frameBusyOUT, frameDoneOUT, pixAddrOUT, txStartOUT, txDataOUT
  );

  modport slave (
    output frameStartIN, brightnessIN, pixDataIN, txBusyIN,
    input  frameBusyOUT, frameDoneOUT, pixAddrOUT, txStartOUT, txDataOUT
  );
endinterface

// File: rtl/ws2811_strip_controller.sv
// WS2811 frame sequencer: reads PIXEL_COUNT GRB words, scales them by a global
// brightness, hands each to the bit transmitter, then holds the latch gap.
`timescale 1ns/1ps
module ws2811_strip_controller #(
  parameter int unsigned CLOCK_SPEED = 50_000_000,
  parameter int unsigned PIXEL_COUNT = 50,
  parameter int unsigned ADDR_WIDTH  = 8,
  parameter int unsigned RESET_US    = 60
) (
  input logic                        clkIN,
  input logic                        nResetIN,
  ws2811_strip_controller_if.master  bus
);
  localparam int unsigned LATCH_CYC = CLOCK_SPEED / 1_000_000 * RESET_US;
  localparam int unsigned CNT_WIDTH = $clog2(LATCH_CYC + 1);
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(PIXEL_COUNT - 1);
  localparam logic [CNT_WIDTH-1:0]  LAST_CNT = CNT_WIDTH'(LATCH_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, FETCH, LOAD, START, WAIT_BUSY, WAIT_IDLE, LATCH
  } state_t;

  state_t                state;
  logic [ADDR_WIDTH-1:0] pixIdx;
  logic [CNT_WIDTH-1:0]  latchCnt;
  logic [7:0]            bright;

  // c * (b + 1) >> 8: b = 255 is a pass-through, b = 0 blanks the channel
  function automatic logic [7:0] scaleChan(input logic [7:0] c, input logic [7:0] b);
    logic [8:0]  bPlus;
    logic [16:0] prod;
    bPlus = 9'(b) + 9'd1;
    prod  = 17'(c) * 17'(bPlus);
    return 8'(prod >> 8);
  endfunction

  function automatic logic [23:0] scaleWord(input logic [23:0] w, input logic [7:0] b);
    return {scaleChan(w[23:16], b), scaleChan(w[15:8], b), scaleChan(w[7:0], b)};
  endfunction

  // The address register is the pixel index, so the RAM sees it throughout FETCH
  assign bus.pixAddrOUT = pixIdx;

  always_ff @(posedge clkIN or negedge nResetIN) begin
    if (!nResetIN) begin
      state            <= IDLE;
      pixIdx           <= '0;
      latchCnt         <= '0;
      bright           <= '0;
      bus.frameBusyOUT <= 1'b0;
      bus.frameDoneOUT <= 1'b0;
      bus.txStartOUT   <= 1'b0;
      bus.txDataOUT    <= '0;
    end else begin
      bus.txStartOUT   <= 1'b0;
      bus.frameDoneOUT <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.frameStartIN) begin
            bright           <= bus.brightnessIN;
            pixIdx           <= '0;
            bus.frameBusyOUT <= 1'b1;
            state            <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          bus.txDataOUT  <= scaleWord(bus.pixDataIN, bright);
          bus.txStartOUT <= 1'b1;
          state          <= START;
        end
        START: state <= WAIT_BUSY;
        WAIT_BUSY: begin
          if (bus.txBusyIN) state <= WAIT_IDLE;
        end
        WAIT_IDLE: begin
          if (!bus.txBusyIN) begin
            if (pixIdx == LAST_IDX) begin
              latchCnt <= '0;
              state    <= LATCH;
            end else begin
              pixIdx <= pixIdx + ADDR_WIDTH'(1);
              state  <= FETCH;
            end
          end
        end
        LATCH: begin
          if (latchCnt == LAST_CNT) begin
            bus.frameDoneOUT <= 1'b1;
            bus.frameBusyOUT <= 1'b0;
            state            <= IDLE;
          end else begin
            latchCnt <= latchCnt + CNT_WIDTH'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
